display_spi_queue: RTL

- Next-generation register-driven SPI display controller: buffers CSR-written command/data words in a FIFO and serialises them onto a write-only display SPI bus.
- Generalised in word width, FIFO depth and number of chip selects; adds its own SPI shifter and rate divider.
- Adds back-to-back transfers, sticky overflow, flush, and control of display reset and panel power.
- Sits between the processor GPIO/CSR bus and one or more SolomonSystech-style OLED panels.

---
 rtl/display_spi_queue_pkg.sv | 43 ++++
 rtl/display_spi_queue_if.sv | 11 +
 rtl/display_spi_queue_fifo.sv | 62 ++++++
 rtl/display_spi_queue.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_spi_queue_pkg.sv
// Shared definitions for the display SPI queue: CSR field positions,
// status bit positions, FSM state encoding and SCLK half-period helper.
package display_spi_pkg;

  localparam int unsigned CSR_W      = 32;

  // GPIO_OUT write fields
  localparam int unsigned FLUSH_BIT  = 31;
  localparam int unsigned CTRL_BIT   = 30;
  localparam int unsigned CS_LSB     = 26;
  localparam int unsigned CS_W       = 3;
  localparam int unsigned LAST_BIT   = 25;
  localparam int unsigned DC_BIT     = 24;
  localparam int unsigned CTRL_RESETN_BIT = 0;
  localparam int unsigned CTRL_VP_BIT     = 1;

  // status word fields
  localparam int unsigned ST_OVF_BIT   = 31;
  localparam int unsigned ST_VP_BIT    = 30;
  localparam int unsigned ST_NRST_BIT  = 29;
  localparam int unsigned ST_BUSY_BIT  = 28;
  localparam int unsigned ST_FULL_BIT  = 27;
  localparam int unsigned ST_EMPTY_BIT = 26;
  localparam int unsigned ST_LEVEL_W   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_WAIT,
    S_GAP
  } spi_state_t;

  // clk cycles per SCLK half period, never less than one
  function automatic int unsigned calc_half(input int unsigned clk_rate,
                                            input int unsigned spi_rate);
    int unsigned h;
    h = clk_rate / (2 * spi_rate);
    return (h == 0) ? 1 : h;
  endfunction

endpackage

// File: rtl/display_spi_queue_if.sv
// CSR-side bus of the display SPI queue: write data, write strobe, status.
interface display_spi_queue_if;
  import display_spi_pkg::*;

  logic [CSR_W-1:0] GPIO_OUT;
  logic             csrStrobe;
  logic [CSR_W-1:0] status;

  modport master (output GPIO_OUT, output csrStrobe, input  status);
  modport slave  (input  GPIO_OUT, input  csrStrobe, output status);
endinterface

// File: rtl/display_spi_queue_fifo.sv
// First-word-fall-through FIFO with level/full/empty and synchronous flush.
// Pushes while full are ignored here; the caller tracks overflow.
module display_spi_fifo #(
  parameter int unsigned DW = 13,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [DW-1:0] o_rdata,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rptr];

  assign w_wr = i_push & ~o_full  & ~i_flush;
  assign w_rd = i_pop  & ~o_empty & ~i_flush;

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/display_spi_queue.sv
// Register-driven SPI display controller: CSR writes are queued in a FIFO
// and shifted out MSB first on a write-only mode-0 SPI bus with per-word
// chip select, D/C, back-to-back bursts, flush and panel power/reset control.
// Optional: `define DISPLAY_SPI_QUEUE_AUTO_RESET_EN adds a post-reset panel
// reset sequencer that holds RESETN low for 10 us and inhibits FIFO pops.
module display_spi_queue
  import display_spi_pkg::*;
#(
  parameter int unsigned CLK_RATE   = 100000000,
  parameter int unsigned SPI_RATE   = 10000000,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned NUM_CS     = 1,
  parameter string       DEBUG      = "false"
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_spi_queue_if.slave   csr,
  output logic                 SPI_CLK,
  output logic [NUM_CS-1:0]    SPI_CSN,
  output logic                 SPI_D_CN,
  output logic                 SPI_DOUT,
  output logic                 VP_ENABLE,
  output logic                 RESETN
);

  localparam int unsigned HALF = calc_half(CLK_RATE, SPI_RATE);
  localparam int unsigned CW   = $clog2(2 * HALF);
  localparam int unsigned BW   = $clog2(2 * DATA_WIDTH);
  localparam int unsigned WW   = DATA_WIDTH + 2 + CS_W;
  localparam logic [CW-1:0] C_HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] C_GAP_END  = CW'(2 * HALF - 1);
  localparam logic [BW-1:0] C_BIT_END  = BW'(2 * DATA_WIDTH - 1);

  // ---------------- CSR decode ----------------
  logic          w_flush;
  logic          w_ctrl;
  logic          w_push;
  logic [WW-1:0] w_push_word;
  logic          w_unused;

  assign w_flush = csr.csrStrobe &  csr.GPIO_OUT[FLUSH_BIT];
  assign w_ctrl  = csr.csrStrobe & ~csr.GPIO_OUT[FLUSH_BIT] &  csr.GPIO_OUT[CTRL_BIT];
  assign w_push  = csr.csrStrobe & ~csr.GPIO_OUT[FLUSH_BIT] & ~csr.GPIO_OUT[CTRL_BIT];
  assign w_push_word = {csr.GPIO_OUT[CS_LSB +: CS_W], csr.GPIO_OUT[LAST_BIT],
                        csr.GPIO_OUT[DC_BIT], csr.GPIO_OUT[DATA_WIDTH-1:0]};
  assign w_unused = ^csr.GPIO_OUT;

  // ---------------- FIFO ----------------
  logic          w_pop;
  logic [WW-1:0] w_head;
  logic [FIFO_AW:0] w_level;
  logic          w_full;
  logic          w_empty;

  display_spi_fifo #(
    .DW (WW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_push_word),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_rdata (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  logic [CS_W-1:0]       w_head_cs;
  logic                  w_head_last;
  logic                  w_head_dc;
  logic [DATA_WIDTH-1:0] w_head_data;

  assign w_head_cs   = w_head[WW-1 -: CS_W];
  assign w_head_last = w_head[DATA_WIDTH+1];
  assign w_head_dc   = w_head[DATA_WIDTH];
  assign w_head_data = w_head[DATA_WIDTH-1:0];

  // ---------------- panel reset sequencer / control ----------------
  logic w_seq_active;

`ifdef DISPLAY_SPI_QUEUE_AUTO_RESET_EN
  localparam int unsigned SEQ_CYC = (CLK_RATE / 100000 == 0) ? 1 : CLK_RATE / 100000;
  localparam int unsigned SW      = $clog2(SEQ_CYC + 1);
  localparam logic        RESETN_INIT = 1'b1;

  logic          r_seq_active;
  logic [SW-1:0] r_seq_cnt;

  // hold the panel in reset for 10 us after rst_n releases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_active <= 1'b1;
      r_seq_cnt    <= '0;
    end else if (r_seq_active) begin
      if (r_seq_cnt == SW'(SEQ_CYC - 1)) r_seq_active <= 1'b0;
      else                               r_seq_cnt    <= r_seq_cnt + SW'(1);
    end
  end

  assign w_seq_active = r_seq_active;
`else
  localparam logic RESETN_INIT = 1'b0;
  assign w_seq_active = 1'b0;
`endif

  logic r_resetn;
  logic r_vpen;
  logic r_ovf;

  // control writes; while the sequencer runs they are held and take effect at its end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resetn <= RESETN_INIT;
      r_vpen   <= 1'b0;
    end else if (w_ctrl) begin
      r_resetn <= csr.GPIO_OUT[CTRL_RESETN_BIT];
      r_vpen   <= csr.GPIO_OUT[CTRL_VP_BIT];
    end
  end

  assign RESETN    = r_resetn & ~w_seq_active;
  assign VP_ENABLE = r_vpen   & ~w_seq_active;

  // sticky overflow: a push into a full FIFO is lost even if a pop coincides
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_ovf <= 1'b0;
    else if (w_flush)          r_ovf <= 1'b0;
    else if (w_push && w_full) r_ovf <= 1'b1;
  end

  // ---------------- shifter FSM ----------------
  spi_state_t r_state, w_nxt_state;
  logic [CW-1:0]         r_cnt,   w_nxt_cnt;
  logic [BW-1:0]         r_bit,   w_nxt_bit;
  logic                  r_act,   w_nxt_act;
  logic [CS_W-1:0]       r_cs,    w_nxt_cs;
  logic                  r_last,  w_nxt_last;
  logic [DATA_WIDTH-1:0] r_shreg, w_nxt_shreg;
  logic [NUM_CS-1:0]     w_nxt_csn;
  logic                  w_nxt_sclk;
  logic                  w_nxt_dc;
  logic                  r_flush_pend;
  logic                  w_half_end;
  logic                  w_head_ok;
  logic                  w_same_cs;
  (* mark_debug = DEBUG *) logic              r_sclk;
  (* mark_debug = DEBUG *) logic              r_dc;
  (* mark_debug = DEBUG *) logic [NUM_CS-1:0] r_csn;

  assign w_half_end = (r_cnt == C_HALF_END);
  assign w_head_ok  = ~w_empty & ~w_seq_active;
  assign w_same_cs  = (w_head_cs == r_cs);

  // next-state and datapath next values; any pop loads the head word and enters SETUP
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_bit   = r_bit;
    w_nxt_sclk  = r_sclk;
    w_nxt_act   = r_act;
    w_nxt_cs    = r_cs;
    w_nxt_last  = r_last;
    w_nxt_dc    = r_dc;
    w_nxt_shreg = r_shreg;
    w_pop       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_head_ok) w_pop = 1'b1;
      end
      S_SETUP: begin
        if (w_half_end) begin
          w_nxt_cnt   = '0;
          w_nxt_bit   = '0;
          w_nxt_state = S_SHIFT;
        end else begin
          w_nxt_cnt = r_cnt + CW'(1);
        end
      end
      S_SHIFT: begin
        if (w_half_end) begin
          w_nxt_cnt  = '0;
          w_nxt_sclk = ~r_sclk;
          if (r_sclk) w_nxt_shreg = r_shreg << 1;
          if (r_bit == C_BIT_END) w_nxt_state = S_HOLD;
          else                    w_nxt_bit   = r_bit + BW'(1);
        end else begin
          w_nxt_cnt = r_cnt + CW'(1);
        end
      end
      S_HOLD: begin
        if (w_half_end) begin
          w_nxt_cnt = '0;
          if (r_last || r_flush_pend || w_flush) begin
            w_nxt_state = S_GAP;
            w_nxt_act   = 1'b0;
          end else if (!w_empty) begin
            if (w_same_cs && w_head_ok) begin
              w_pop = 1'b1;
            end else begin
              w_nxt_state = S_GAP;
              w_nxt_act   = 1'b0;
            end
          end else begin
            w_nxt_state = S_WAIT;
          end
        end else begin
          w_nxt_cnt = r_cnt + CW'(1);
        end
      end
      S_WAIT: begin
        w_nxt_cnt = '0;
        if (r_flush_pend || w_flush) begin
          w_nxt_state = S_GAP;
          w_nxt_act   = 1'b0;
        end else if (!w_empty) begin
          if (w_same_cs && w_head_ok) begin
            w_pop = 1'b1;
          end else begin
            w_nxt_state = S_GAP;
            w_nxt_act   = 1'b0;
          end
        end
      end
      S_GAP: begin
        // a queued word starts straight from the end of GAP so the CSN-high
        // time is exactly 2*HALF; otherwise fall back to IDLE
        if (r_cnt == C_GAP_END) begin
          w_nxt_cnt = '0;
          if (w_head_ok) w_pop = 1'b1;
          else           w_nxt_state = S_IDLE;
        end else begin
          w_nxt_cnt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_act   = 1'b0;
      end
    endcase

    if (w_pop) begin
      w_nxt_state = S_SETUP;
      w_nxt_cnt   = '0;
      w_nxt_sclk  = 1'b0;
      w_nxt_act   = 1'b1;
      w_nxt_cs    = w_head_cs;
      w_nxt_last  = w_head_last;
      w_nxt_dc    = w_head_dc;
      w_nxt_shreg = w_head_data;
    end

    for (int unsigned i = 0; i < NUM_CS; i++) begin
      w_nxt_csn[i] = ~(w_nxt_act && (w_nxt_cs == CS_W'(i)));
    end
  end

  // FSM and SPI output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sclk  <= 1'b0;
      r_act   <= 1'b0;
      r_cs    <= '0;
      r_last  <= 1'b0;
      r_dc    <= 1'b0;
      r_shreg <= '0;
      r_csn   <= '1;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_bit   <= w_nxt_bit;
      r_sclk  <= w_nxt_sclk;
      r_act   <= w_nxt_act;
      r_cs    <= w_nxt_cs;
      r_last  <= w_nxt_last;
      r_dc    <= w_nxt_dc;
      r_shreg <= w_nxt_shreg;
      r_csn   <= w_nxt_csn;
    end
  end

  // flush seen mid-transfer: finish the current word, then release CSN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_flush_pend <= 1'b0;
    else if (w_nxt_state == S_IDLE || w_nxt_state == S_GAP)
      r_flush_pend <= 1'b0;
    else if (w_flush && r_state != S_IDLE && r_state != S_GAP)
      r_flush_pend <= 1'b1;
  end

  assign SPI_CLK  = r_sclk;
  assign SPI_CSN  = r_csn;
  assign SPI_D_CN = r_dc;
  assign SPI_DOUT = r_shreg[DATA_WIDTH-1];

  // ---------------- status word ----------------
  logic [CSR_W-1:0] w_status;

  // status assembled from registered state
  always_comb begin
    w_status               = '0;
    w_status[ST_OVF_BIT]   = r_ovf;
    w_status[ST_VP_BIT]    = VP_ENABLE;
    w_status[ST_NRST_BIT]  = ~RESETN;
    w_status[ST_BUSY_BIT]  = (r_state != S_IDLE) | w_seq_active;
    w_status[ST_FULL_BIT]  = w_full;
    w_status[ST_EMPTY_BIT] = w_empty;
    w_status[ST_LEVEL_W-1:0] = ST_LEVEL_W'(w_level);
  end

  assign csr.status = w_status;

endmodule
